ram_arbiter: RTL

- Two-requester round-robin arbiter and access sequencer for the 256x8 ram_storage block.
- Serialises requester transactions onto the RAM's cs/rw/addr/data_in/data_out interface.
- Holds addr/rw/data_in stable for the whole cs-active window, because the RAM writes level-sensitively.
- Returns read data with a one-cycle ack pulse. Sits between the CPU-side and DMA-side masters and the RAM.

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_arbiter_if.sv | 37 +++
 rtl/rr_select2.sv | 15 +
 rtl/ram_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ram_pkg: state encoding, direction codes and default geometry shared by the RAM arbiter slice.
package ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 8;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ram_arbiter_if: two-requester bus plus the RAM-side port of the arbiter.
interface ram_arbiter_if
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);
  logic              req0;
  logic              rw0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              req1;
  logic              rw1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              ram_cs;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, ram_rdata,
    output ack0, ack1, rdata, busy, ram_cs, ram_rw, ram_addr, ram_wdata
  );

  modport master (
    output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, ram_rdata,
    input  ack0, ack1, rdata, busy, ram_cs, ram_rw, ram_addr, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/rr_select2.sv
`default_nettype none
// rr_select2: combinational two-way round-robin pick; rr_ptr breaks ties only.
module rr_select2 (
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic grant_valid,
  output logic grant_id
);
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = (req0 & req1) ? rr_ptr : req1;
  end
endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ram_arbiter: round-robin arbiter that sequences two requesters onto a level-sensitive RAM.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W        = RAM_ADDR_W,
  parameter int DATA_W        = RAM_DATA_W,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_arbiter_if.slave bus
);
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              gid_q, gid_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              cs_q, cs_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic              grant_valid;
  logic              grant_id;

  rr_select2 u_sel (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .rr_ptr      (rr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      gid_q   <= 1'b0;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  // Every output is computed one cycle ahead so the registered copy lines up with its state.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          rw_d    = grant_id ? bus.rw1    : bus.rw0;
          addr_d  = grant_id ? bus.addr1  : bus.addr0;
          wdata_d = grant_id ? bus.wdata1 : bus.wdata0;
          gid_d   = grant_id;
          rr_d    = ~grant_id;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = CNT_INIT;
        cs_d    = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (rw_q == RW_READ) rdata_d = bus.ram_rdata;
          cs_d    = 1'b0;
          ack0_d  = ~gid_q;
          ack1_d  = gid_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Park on read so a stray chip select can never corrupt memory.
        rw_d    = RW_READ;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.ram_cs    = cs_q;
  assign bus.ram_rw    = rw_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;

endmodule
`default_nettype wire
